// File: rtl/lif_neuron_array_pkg.sv
// Shared types and helpers for the LIF neuron array: FSM states, decay shift,
// and a generic signed saturation used by both the accumulator and voltage paths.
package lif_neuron_array_pkg;

  localparam int DECAY_SHIFT = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_STALL,
    S_DONE
  } state_t;

  // Clamp a 64-bit signed value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Event input and spike output streams of the neuron array (valid/ready).
interface lif_neuron_array_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [IDX_W-1:0]  in_idx;
  logic [DATA_W-1:0] in_current;
  logic              spike_valid;
  logic              spike_ready;
  logic [IDX_W-1:0]  spike_idx;

  modport master (
    output in_valid, in_idx, in_current, spike_ready,
    input  in_ready, spike_valid, spike_idx
  );

  modport slave (
    input  in_valid, in_idx, in_current, spike_ready,
    output in_ready, spike_valid, spike_idx
  );
endinterface

// File: rtl/lif_neuron_array_update_core.sv
// Combinational single-neuron LIF update: leak, integrate, threshold, refractory.
module lif_update_core
  import lif_neuron_array_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int FRAC_W        = 8,
  parameter int V_THRESH      = 256,
  parameter int V_RESET       = 0,
  parameter int V_REST        = 0,
  parameter int DECAY_FACTOR  = 243,
  parameter int REFRAC_W      = 8,
  parameter int REFRAC_CYCLES = 1
) (
  input  logic signed [DATA_W+FRAC_W-1:0] i_v,
  input  logic signed [DATA_W-1:0]        i_acc,
  input  logic        [REFRAC_W-1:0]      i_cnt,
  output logic signed [DATA_W+FRAC_W-1:0] o_v,
  output logic        [REFRAC_W-1:0]      o_cnt,
  output logic                            o_spike
);
  localparam int VW = DATA_W + FRAC_W;
  localparam logic signed [63:0] TH_FX    = 64'(V_THRESH) <<< FRAC_W;
  localparam logic signed [63:0] RESET_FX = 64'(V_RESET) <<< FRAC_W;
  localparam logic signed [63:0] REST_FX  = 64'(V_REST) <<< FRAC_W;

  logic signed [63:0] w_prod;
  logic signed [63:0] w_dec;
  logic signed [63:0] w_sum;
  logic signed [63:0] w_vn;

  always_comb begin
    w_prod  = 64'(i_v) * 64'(DECAY_FACTOR);
    w_dec   = w_prod >>> DECAY_SHIFT;
    w_sum   = w_dec + (64'(i_acc) <<< FRAC_W);
    w_vn    = sat_s(w_sum, VW);
    o_v     = i_v;
    o_cnt   = i_cnt;
    o_spike = 1'b0;
    if (i_cnt != '0) begin
      // Refractory: input is discarded; voltage snaps to rest on the last step.
      o_cnt = i_cnt - REFRAC_W'(1);
      if (i_cnt == REFRAC_W'(1)) o_v = VW'(REST_FX);
    end else if (w_vn >= TH_FX) begin
      o_spike = 1'b1;
      o_v     = VW'(RESET_FX);
      o_cnt   = REFRAC_W'(REFRAC_CYCLES);
    end else begin
      o_v = VW'(w_vn);
    end
  end
endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: events accumulate while idle, a tick sweeps
// every neuron through one shared update core, spikes leave on a valid/ready stream.
module lif_neuron_array
  import lif_neuron_array_pkg::*;
#(
  parameter int unsigned NUM_NEURONS   = 16,
  parameter int          IDX_W         = 4,
  parameter int          DATA_W        = 16,
  parameter int          FRAC_W        = 8,
  parameter int          V_THRESH      = 256,
  parameter int          V_RESET       = 0,
  parameter int          V_REST        = 0,
  parameter int          DECAY_FACTOR  = 243,
  parameter int          REFRAC_W      = 8,
  parameter int          REFRAC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  lif_neuron_array_if.slave  bus,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic               overrun,
  input  logic [IDX_W-1:0]   probe_idx,
  output logic [DATA_W-1:0]  probe_voltage
);
  localparam int VW = DATA_W + FRAC_W;
  localparam logic signed [VW-1:0] V_REST_FX = VW'(64'(V_REST) <<< FRAC_W);

  logic signed [VW-1:0]     r_v   [NUM_NEURONS];
  logic signed [DATA_W-1:0] r_acc [NUM_NEURONS];
  logic [REFRAC_W-1:0]      r_cnt [NUM_NEURONS];

  state_t               r_state;
  state_t               w_state_next;
  logic [IDX_W-1:0]     r_ptr;
  logic                 r_spike_valid;
  logic [IDX_W-1:0]     r_spike_idx;
  logic                 r_overrun;
  logic [DATA_W-1:0]    r_probe;

  logic                 w_stall;
  logic                 w_update;
  logic                 w_last;
  logic                 w_done;
  logic                 w_accept;
  logic signed [VW-1:0] w_v_next;
  logic [REFRAC_W-1:0]  w_cnt_next;
  logic                 w_spike;

  lif_update_core #(
    .DATA_W       (DATA_W),
    .FRAC_W       (FRAC_W),
    .V_THRESH     (V_THRESH),
    .V_RESET      (V_RESET),
    .V_REST       (V_REST),
    .DECAY_FACTOR (DECAY_FACTOR),
    .REFRAC_W     (REFRAC_W),
    .REFRAC_CYCLES(REFRAC_CYCLES)
  ) u_core (
    .i_v    (r_v[r_ptr]),
    .i_acc  (r_acc[r_ptr]),
    .i_cnt  (r_cnt[r_ptr]),
    .o_v    (w_v_next),
    .o_cnt  (w_cnt_next),
    .o_spike(w_spike)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_stall      = r_spike_valid && !bus.spike_ready;
    w_update     = (r_state == S_SWEEP) && !w_stall;
    w_last       = (r_ptr == IDX_W'(NUM_NEURONS - 1));
    w_accept     = (r_state == S_IDLE) && bus.in_valid;
    unique case (r_state)
      S_IDLE:  if (tick) w_state_next = S_SWEEP;
      S_SWEEP: begin
        if (w_stall)     w_state_next = S_STALL;
        else if (w_last) w_state_next = S_DONE;
      end
      S_STALL: if (bus.spike_ready) w_state_next = S_SWEEP;
      S_DONE: begin
        // The final spike may be handed off in the same cycle sweep_done pulses.
        if (!w_stall) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    bus.in_ready = (r_state == S_IDLE);
    sweep_busy   = (r_state != S_IDLE) && !w_done;
    sweep_done   = w_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
        r_v[n]   <= V_REST_FX;
        r_acc[n] <= '0;
        r_cnt[n] <= '0;
      end
    end else if (w_update) begin
      r_v[r_ptr]   <= w_v_next;
      r_cnt[r_ptr] <= w_cnt_next;
      r_acc[r_ptr] <= '0;
    end else if (w_accept && (32'(bus.in_idx) < NUM_NEURONS)) begin
      r_acc[bus.in_idx] <= DATA_W'(sat_s(64'(r_acc[bus.in_idx]) +
                                         64'($signed(bus.in_current)), DATA_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr         <= '0;
      r_spike_valid <= 1'b0;
      r_spike_idx   <= '0;
      r_overrun     <= 1'b0;
      r_probe       <= '0;
    end else begin
      if (r_state == S_IDLE && tick) r_ptr <= '0;
      else if (w_update)             r_ptr <= w_last ? '0 : r_ptr + IDX_W'(1);

      if (w_update && w_spike) begin
        r_spike_valid <= 1'b1;
        r_spike_idx   <= r_ptr;
      end else if (r_spike_valid && bus.spike_ready) begin
        r_spike_valid <= 1'b0;
      end

      if (tick && r_state != S_IDLE) r_overrun <= 1'b1;

      if (32'(probe_idx) < NUM_NEURONS) r_probe <= r_v[probe_idx][VW-1:FRAC_W];
      else                              r_probe <= '0;
    end
  end

  assign bus.spike_valid = r_spike_valid;
  assign bus.spike_idx   = r_spike_idx;
  assign overrun         = r_overrun;
  assign probe_voltage   = r_probe;
endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array with hand-computed expectations.
module tb_lif_neuron_array;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              sweep_busy;
  logic              sweep_done;
  logic              overrun;
  logic [IDX_W-1:0]  probe_idx;
  logic [DATA_W-1:0] probe_voltage;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int spikes[$];

  lif_neuron_array_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

  lif_neuron_array #(
    .NUM_NEURONS  (16),
    .IDX_W        (IDX_W),
    .DATA_W       (DATA_W),
    .FRAC_W       (8),
    .V_THRESH     (256),
    .V_RESET      (0),
    .V_REST       (0),
    .DECAY_FACTOR (243),
    .REFRAC_W     (8),
    .REFRAC_CYCLES(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .bus          (bus),
    .sweep_busy   (sweep_busy),
    .sweep_done   (sweep_done),
    .overrun      (overrun),
    .probe_idx    (probe_idx),
    .probe_voltage(probe_voltage)
  );

  always #5 clk = ~clk;

  // Log every accepted spike; inputs are stable at the falling edge.
  always @(negedge clk)
    if (!rst && bus.spike_valid && bus.spike_ready) spikes.push_back(int'(bus.spike_idx));

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_event(input int idx, input int cur);
    bus.in_valid   = 1'b1;
    bus.in_idx     = IDX_W'(idx);
    bus.in_current = DATA_W'(cur);
    step();
    bus.in_valid   = 1'b0;
  endtask

  task automatic run_sweep(output int l);
    spikes.delete();
    tick = 1'b1;
    step();
    tick = 1'b0;
    l = 1;
    while (!sweep_done && l < 200) begin
      step();
      l++;
    end
    step();
  endtask

  task automatic probe(input int idx, input string tag, input int exp);
    probe_idx = IDX_W'(idx);
    step();
    check_eq(tag, longint'($signed(probe_voltage)), exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, bus.in_ready, 1);
    check_eq({tag, "_spike_valid"}, bus.spike_valid, 0);
    check_eq({tag, "_spike_idx"}, bus.spike_idx, 0);
    check_eq({tag, "_busy"}, sweep_busy, 0);
    check_eq({tag, "_done"}, sweep_done, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    check_eq({tag, "_probe"}, probe_voltage, 0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; probe_idx = '0;
    bus.in_valid = 1'b0; bus.in_idx = '0; bus.in_current = '0; bus.spike_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check_reset_outputs("rst");

    for (int i = 0; i < 16; i++) probe(i, "probe_init", 0);

    run_sweep(lat);
    check_eq("idle_sweep_latency", lat, 17);
    check_eq("idle_sweep_spikes", spikes.size(), 0);
    check_eq("done_one_cycle", sweep_done, 0);

    // 300<<8 = 76800 >= 65536: fires, voltage to reset, one refractory step follows.
    send_event(3, 300);
    run_sweep(lat);
    check_eq("fire3_count", spikes.size(), 1);
    if (spikes.size() > 0) check_eq("fire3_idx", spikes[0], 3);
    probe(3, "fire3_probe", 0);

    send_event(3, 300);
    run_sweep(lat);
    check_eq("refrac3_count", spikes.size(), 0);
    probe(3, "refrac3_probe", 0);

    send_event(3, 300);
    run_sweep(lat);
    check_eq("rearm3_count", spikes.size(), 1);
    if (spikes.size() > 0) check_eq("rearm3_idx", spikes[0], 3);

    // 100<<8 = 25600; next sweep 25600*243>>8 = 24300 -> integer part 94.
    send_event(5, 100);
    run_sweep(lat);
    probe(5, "leak5_first", 100);
    run_sweep(lat);
    probe(5, "leak5_second", 94);

    // Spike stall: first spike (neuron 1) appears 3 cycles after tick; ready held
    // low for 5 cycles, sweep resumes the cycle after acceptance -> 6-cycle delay.
    send_event(1, 300);
    send_event(2, 300);
    send_event(9, 300);
    spikes.delete();
    bus.spike_ready = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    lat = 1;
    while (!bus.spike_valid && lat < 200) begin
      step();
      lat++;
    end
    check_eq("stall_first_cycle", lat, 3);
    check_eq("stall_first_idx", bus.spike_idx, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      lat++;
      check_eq("stall_hold_valid", bus.spike_valid, 1);
      check_eq("stall_hold_idx", bus.spike_idx, 1);
    end
    step();
    lat++;
    bus.spike_ready = 1'b1;
    check_eq("stall_busy", sweep_busy, 1);
    while (!sweep_done && lat < 200) begin
      step();
      lat++;
    end
    check_eq("stall_latency", lat, 23);
    step();
    check_eq("stall_count", spikes.size(), 3);
    if (spikes.size() == 3) begin
      check_eq("stall_order0", spikes[0], 1);
      check_eq("stall_order1", spikes[1], 2);
      check_eq("stall_order2", spikes[2], 9);
    end

    // Overrun: a second tick mid-sweep is ignored but latches overrun.
    check_eq("overrun_pre", overrun, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    lat = 1;
    repeat (3) begin
      step();
      lat++;
    end
    tick = 1'b1;
    step();
    lat++;
    tick = 1'b0;
    check_eq("overrun_set", overrun, 1);
    while (!sweep_done && lat < 200) begin
      step();
      lat++;
    end
    check_eq("overrun_latency", lat, 17);
    step();
    run_sweep(lat);
    check_eq("overrun_sticky", overrun, 1);

    // Accumulator saturation: +32767 twice stays 32767 (fires); wrap would give -2.
    // -32768 twice stays -32768, i.e. voltage pinned at the 24-bit minimum.
    send_event(0, 32767);
    send_event(0, 32767);
    send_event(7, -32768);
    send_event(7, -32768);
    run_sweep(lat);
    check_eq("sat_pos_count", spikes.size(), 1);
    if (spikes.size() > 0) check_eq("sat_pos_idx", spikes[0], 0);
    probe(7, "sat_neg_probe", -32768);

    // Reset in the middle of a stalled sweep.
    send_event(4, 300);
    bus.spike_ready = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    lat = 1;
    while (!bus.spike_valid && lat < 200) begin
      step();
      lat++;
    end
    check_eq("midrst_spike_idx", bus.spike_idx, 4);
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst = 1'b0;
    bus.spike_ready = 1'b1;
    probe(7, "midrst_probe7", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
